// File: rtl/rf_mp.sv
// rf_mp: parametrised multi-ported register file with bypass, read hold and pending scoreboard
module rf_mp #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_en,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd0,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pend, pend_nxt;
  logic w0, w1, ps;
  // drop writes and pend_set aimed at a hardwired zero register
  always_comb begin
    w0 = we0 && !(ZERO_REG != 0 && wa0 == '0);
    w1 = we1 && !(ZERO_REG != 0 && wa1 == '0);
    ps = pend_set && !(ZERO_REG != 0 && pend_addr == '0);
  end
  // commit writes; port 1 is assigned last so it wins an address collision
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
    else begin
      if (w0) mem[wa0] <= wd0;
      if (w1) mem[wa1] <= wd1;
    end
  // completing writes clear, then a newly issued producer sets and supersedes them
  always_comb begin
    pend_nxt = pend;
    if (we0) pend_nxt[wa0] = 1'b0;
    if (we1) pend_nxt[wa1] = 1'b0;
    if (ps) pend_nxt[pend_addr] = 1'b1;
  end
  // scoreboard register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend <= '0;
    else pend <= pend_nxt;
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic z, h0, h1;
    logic [DATA_W-1:0] live, hold;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];
    assign z = ZERO_REG != 0 && a == '0;
    assign h0 = we0 && wa0 == a;
    assign h1 = we1 && wa1 == a;
    assign live = z ? '0 : h1 ? wd1 : h0 ? wd0 : mem[a];
    // hold whatever this port presented on its last enabled cycle
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) hold <= '0;
      else if (rd_en[i]) hold <= live;
    assign rd_data[i*DATA_W +: DATA_W] = !rst_n ? '0 : rd_en[i] ? live : hold;
    assign rd_pend[i] = rst_n && pend[a] && !h0 && !h1 && !z;
  end
endmodule

// File: tb/tb_rf_mp.sv
// tb_rf_mp: random and directed checks of two rf_mp configurations against a behavioural model
module tb_rf_mp;
  localparam int AW [2] = '{4, 5};
  localparam int NR [2] = '{2, 4};
  localparam int ZR [2] = '{1, 0};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic we0 [2], we1 [2], ps [2];
  logic [4:0] wa0 [2], wa1 [2], pa [2];
  logic [31:0] wd0 [2], wd1 [2];
  logic [4:0] ra [2][4];
  logic [3:0] re [2];
  logic [31:0] rdd0;
  logic [127:0] rdd1;
  logic [1:0] rdp0;
  logic [3:0] rdp1;
  logic [31:0] mm [2][32];
  logic [31:0] pp [2];
  logic [31:0] hh [2][4];
  int n_cmp = 0, n_bad = 0;

  rf_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .rd_addr({ra[0][1][3:0], ra[0][0][3:0]}), .rd_en(re[0][1:0]),
    .rd_data(rdd0), .rd_pend(rdp0),
    .we0(we0[0]), .we1(we1[0]), .wa0(wa0[0][3:0]), .wa1(wa1[0][3:0]),
    .wd0(wd0[0][15:0]), .wd1(wd1[0][15:0]),
    .pend_set(ps[0]), .pend_addr(pa[0][3:0]));

  rf_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(0)) u1 (
    .clk(clk), .rst_n(rst_n),
    .rd_addr({ra[1][3], ra[1][2], ra[1][1], ra[1][0]}), .rd_en(re[1]),
    .rd_data(rdd1), .rd_pend(rdp1),
    .we0(we0[1]), .we1(we1[1]), .wa0(wa0[1]), .wa1(wa1[1]),
    .wd0(wd0[1]), .wd1(wd1[1]),
    .pend_set(ps[1]), .pend_addr(pa[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] got_d(int k, int i);
    return k == 0 ? {16'h0, rdd0[i*16 +: 16]} : rdd1[i*32 +: 32];
  endfunction

  function automatic logic [31:0] got_p(int k, int i);
    return {31'h0, k == 0 ? rdp0[i] : rdp1[i]};
  endfunction

  function automatic logic [31:0] live(int k, int i);
    logic [4:0] a = ra[k][i];
    if (ZR[k] != 0 && a == 0) return 32'h0;
    if (we1[k] && wa1[k] == a) return wd1[k];
    if (we0[k] && wa0[k] == a) return wd0[k];
    return mm[k][a];
  endfunction

  function automatic logic [31:0] exp_d(int k, int i);
    if (!rst_n) return 32'h0;
    return re[k][i] ? live(k, i) : hh[k][i];
  endfunction

  function automatic logic [31:0] exp_p(int k, int i);
    logic [4:0] a = ra[k][i];
    logic busy = (we0[k] && wa0[k] == a) || (we1[k] && wa1[k] == a);
    return {31'h0, rst_n && pp[k][a] && !busy && !(ZR[k] != 0 && a == 0)};
  endfunction

  function automatic void rst_model();
    for (int k = 0; k < 2; k++) begin
      pp[k] = 32'h0;
      for (int j = 0; j < 32; j++) mm[k][j] = 32'h0;
      for (int i = 0; i < 4; i++) hh[k][i] = 32'h0;
    end
  endfunction

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      we0[k] = 1'b0; we1[k] = 1'b0; ps[k] = 1'b0;
      wa0[k] = 5'd0; wa1[k] = 5'd0; pa[k] = 5'd0;
      wd0[k] = 32'h0; wd1[k] = 32'h0; re[k] = 4'h0;
      for (int i = 0; i < 4; i++) ra[k][i] = 5'd0;
    end
  endtask

  function automatic logic [4:0] ad(int k);
    logic [4:0] m = 5'((1 << AW[k]) - 1);
    return ($urandom % 4 == 0) ? 5'($urandom % 3) : 5'($urandom) & m;
  endfunction

  task automatic rnd();
    for (int k = 0; k < 2; k++) begin
      we0[k] = 1'($urandom); we1[k] = 1'($urandom);
      ps[k] = ($urandom % 3 == 0);
      wa0[k] = ad(k); wa1[k] = ad(k); pa[k] = ad(k);
      wd0[k] = k == 0 ? $urandom & 32'hFFFF : $urandom;
      wd1[k] = k == 0 ? $urandom & 32'hFFFF : $urandom;
      re[k] = 4'($urandom) & 4'((1 << NR[k]) - 1);
      for (int i = 0; i < 4; i++) ra[k][i] = ad(k);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR[k]; i++) begin
        chk($sformatf("data u%0d p%0d", k, i), got_d(k, i), exp_d(k, i));
        chk($sformatf("pend u%0d p%0d", k, i), got_p(k, i), exp_p(k, i));
      end
  endtask

  task automatic commit();
    @(posedge clk);
    if (!rst_n) rst_model();
    else for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NR[k]; i++) if (re[k][i]) hh[k][i] = live(k, i);
      if (we0[k] && !(ZR[k] != 0 && wa0[k] == 0)) mm[k][wa0[k]] = wd0[k];
      if (we1[k] && !(ZR[k] != 0 && wa1[k] == 0)) mm[k][wa1[k]] = wd1[k];
      if (we0[k]) pp[k][wa0[k]] = 1'b0;
      if (we1[k]) pp[k][wa1[k]] = 1'b0;
      if (ps[k] && !(ZR[k] != 0 && pa[k] == 0)) pp[k][pa[k]] = 1'b1;
    end
    #1;
  endtask

  initial begin
    idle();
    rst_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sample();
    chk("reset data", rdd0, 32'h0);
    commit();
    idle(); we0[0] = 1'b1; wa0[0] = 5'd5; wd0[0] = 32'hBEEF; sample(); commit();
    idle(); re[0] = 4'h3; ra[0][0] = 5'd5; ra[0][1] = 5'd5; sample();
    chk("r5 p0", got_d(0, 0), 32'hBEEF); chk("r5 p1", got_d(0, 1), 32'hBEEF); commit();
    idle(); we0[0] = 1'b1; wa0[0] = 5'd3; wd0[0] = 32'h1111;
    we1[0] = 1'b1; wa1[0] = 5'd3; wd1[0] = 32'h2222; re[0] = 4'h1; ra[0][0] = 5'd3; sample();
    chk("prio bypass", got_d(0, 0), 32'h2222); commit();
    idle(); re[0] = 4'h1; ra[0][0] = 5'd3; sample(); chk("prio stored", got_d(0, 0), 32'h2222); commit();
    idle(); we0[0] = 1'b1; wa0[0] = 5'd7; wd0[0] = 32'h00A5; sample(); commit();
    idle(); re[0] = 4'h1; ra[0][0] = 5'd7; sample(); chk("hold load", got_d(0, 0), 32'h00A5); commit();
    idle(); ra[0][0] = 5'd7; we0[0] = 1'b1; wa0[0] = 5'd7; wd0[0] = 32'hFFFF; sample();
    chk("hold write", got_d(0, 0), 32'h00A5); commit();
    idle(); ra[0][0] = 5'd7; sample(); chk("hold idle", got_d(0, 0), 32'h00A5); commit();
    idle(); re[0] = 4'h1; ra[0][0] = 5'd7; sample(); chk("hold release", got_d(0, 0), 32'hFFFF); commit();
    idle();
    for (int k = 0; k < 2; k++) begin
      we0[k] = 1'b1; wd0[k] = 32'h1234; ps[k] = 1'b1; re[k] = 4'h1;
    end
    sample();
    chk("zero data", got_d(0, 0), 32'h0); chk("zero pend", got_p(0, 0), 32'h0);
    chk("nozero bypass", got_d(1, 0), 32'h1234); chk("nozero pend same", got_p(1, 0), 32'h0);
    commit();
    idle(); re[0] = 4'h1; re[1] = 4'h1; sample();
    chk("zero data next", got_d(0, 0), 32'h0); chk("zero pend next", got_p(0, 0), 32'h0);
    chk("nozero stored", got_d(1, 0), 32'h1234); chk("nozero pend next", got_p(1, 0), 32'h1);
    commit();
    idle(); ps[0] = 1'b1; pa[0] = 5'd9; ra[0][0] = 5'd9; sample();
    chk("sb before edge", got_p(0, 0), 32'h0); commit();
    idle(); ra[0][0] = 5'd9; sample(); chk("sb set", got_p(0, 0), 32'h1); commit();
    idle(); we1[0] = 1'b1; wa1[0] = 5'd9; wd1[0] = 32'h0042; re[0] = 4'h1; ra[0][0] = 5'd9; sample();
    chk("sb write pend", got_p(0, 0), 32'h0); chk("sb write data", got_d(0, 0), 32'h0042); commit();
    idle(); ra[0][0] = 5'd9; sample(); chk("sb cleared", got_p(0, 0), 32'h0); commit();
    idle(); ps[0] = 1'b1; pa[0] = 5'd9; we0[0] = 1'b1; wa0[0] = 5'd9; wd0[0] = 32'h7; ra[0][0] = 5'd9;
    sample(); commit();
    idle(); ra[0][0] = 5'd9; sample(); chk("sb set wins", got_p(0, 0), 32'h1); commit();
    idle(); we0[1] = 1'b1; wa0[1] = 5'd31; wd0[1] = 32'h31313131; sample(); commit();
    idle(); re[1] = 4'hF; ra[1][0] = 5'd31; ra[1][1] = 5'd0; ra[1][2] = 5'd16; ra[1][3] = 5'd31;
    we1[1] = 1'b1; wa1[1] = 5'd16; wd1[1] = 32'hCAFEF00D; sample();
    chk("scale p0", got_d(1, 0), 32'h31313131); chk("scale p1", got_d(1, 1), 32'h1234);
    chk("scale p2", got_d(1, 2), 32'hCAFEF00D); chk("scale p3", got_d(1, 3), 32'h31313131);
    commit();
    for (int c = 0; c < 300; c++) begin rnd(); sample(); commit(); end
    rnd();
    #2 rst_n = 1'b0;
    sample();
    chk("midreset data0", rdd0, 32'h0); chk("midreset data1", rdd1[31:0], 32'h0);
    chk("midreset pend", {28'h0, rdp1}, {30'h0, rdp0});
    commit();
    #1 rst_n = 1'b1;
    idle(); re[0] = 4'h1; ra[0][0] = 5'd5; sample(); chk("after reset r5", got_d(0, 0), 32'h0); commit();
    for (int c = 0; c < 10000; c++) begin rnd(); sample(); commit(); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
